// File: rtl/neuron_lut_pkg.sv
// Shared types and sizing helpers for the programmable neuron truth table.
package neuron_lut_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2
    } state_e;

    function automatic int calc_epw(input int word_w, input int out_bits);
        return word_w / out_bits;
    endfunction

    function automatic int calc_nwords(input int in_bits, input int word_w, input int out_bits);
        return (1 << in_bits) / calc_epw(word_w, out_bits);
    endfunction

    function automatic int cnt_w(input int nwords);
        return (nwords > 1) ? $clog2(nwords) : 1;
    endfunction

    // Word-counter width for the default 8-in / 1-out / 8-bit-word configuration.
    localparam int WCNT_W = cnt_w(calc_nwords(8, 8, 1));

endpackage

// File: rtl/neuron_lut_ram.sv
// DEPTH x OUT_BITS distributed table: one EPW-entry word write port, one registered read port.
// NEURON_LUT_READBACK_EN adds an asynchronous word-wide read port for table readback.
module neuron_lut_ram
    import neuron_lut_pkg::*;
#(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int WORD_W   = 8
)(
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                we_i,
    input  logic [cnt_w(calc_nwords(IN_BITS, WORD_W, OUT_BITS))-1:0] waddr_i,
    input  logic [WORD_W-1:0]                                   wdata_i,
    input  logic                                                re_i,
    input  logic [IN_BITS-1:0]                                  raddr_i,
    output logic [OUT_BITS-1:0]                                 rdata_o
`ifdef NEURON_LUT_READBACK_EN
    ,
    input  logic [cnt_w(calc_nwords(IN_BITS, WORD_W, OUT_BITS))-1:0] rb_addr_i,
    output logic [WORD_W-1:0]                                   rb_word_o
`endif
);

    localparam int DEPTH  = 1 << IN_BITS;
    localparam int EPW    = calc_epw(WORD_W, OUT_BITS);
    localparam int NWORDS = calc_nwords(IN_BITS, WORD_W, OUT_BITS);
    localparam int CW     = cnt_w(NWORDS);

    (* rom_style = "distributed", ram_style = "distributed" *)
    logic [OUT_BITS-1:0] mem_q [DEPTH];
    logic [OUT_BITS-1:0] rdata_q;

    function automatic logic [IN_BITS-1:0] ent_addr(input logic [CW-1:0] w, input int j);
        return IN_BITS'(int'(w) * EPW + j);
    endfunction

    // Table contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int j = 0; j < EPW; j++) begin
                mem_q[ent_addr(waddr_i, j)] <= wdata_i[j*OUT_BITS +: OUT_BITS];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

`ifdef NEURON_LUT_READBACK_EN
    always_comb begin
        rb_word_o = '0;
        for (int j = 0; j < EPW; j++) begin
            rb_word_o[j*OUT_BITS +: OUT_BITS] = mem_q[ent_addr(rb_addr_i, j)];
        end
    end
`endif

endmodule

// File: rtl/neuron_lut_prog.sv
// Runtime-loadable neuron truth table: valid/ready word loader, framing check, 1-cycle lookup.
// Define NEURON_LUT_READBACK_EN to add the rb_* table readback stream.
//
// state | meaning
// IDLE  | no valid table (after reset or a framing error)
// LOAD  | accepting table words, s_ready high
// ARMED | table complete, lookups answered
module neuron_lut_prog
    import neuron_lut_pkg::*;
#(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int WORD_W   = 8
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                load_start,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [WORD_W-1:0]   s_data,
    input  logic                s_last,
    output logic                armed,
    output logic                err,
    input  logic                in_valid,
    input  logic [IN_BITS-1:0]  M0,
    output logic [OUT_BITS-1:0] M1,
    output logic                out_valid
`ifdef NEURON_LUT_READBACK_EN
    ,
    input  logic                rb_start,
    output logic                rb_valid,
    input  logic                rb_ready,
    output logic [WORD_W-1:0]   rb_data,
    output logic                rb_last
`endif
);

    localparam int NWORDS = calc_nwords(IN_BITS, WORD_W, OUT_BITS);
    localparam int CW     = cnt_w(NWORDS);

    state_e        state_q;
    logic [CW-1:0] wcnt_q;
    logic          armed_q, err_q, s_ready_q, out_valid_q;
    logic          last_word, wr_en, rd_en;

    assign last_word = (wcnt_q == CW'(NWORDS - 1));
    // A word arriving together with a restart is dropped.
    assign wr_en     = (state_q == LOAD) && s_valid && !load_start;
    assign rd_en     = (state_q == ARMED) && in_valid && !load_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            armed_q     <= 1'b0;
            err_q       <= 1'b0;
            s_ready_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= rd_en;
            case (state_q)
                IDLE, ARMED: begin
                    if (load_start) begin
                        state_q   <= LOAD;
                        wcnt_q    <= '0;
                        err_q     <= 1'b0;
                        armed_q   <= 1'b0;
                        s_ready_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_start) begin
                        wcnt_q <= '0;
                        err_q  <= 1'b0;
                    end else if (s_valid) begin
                        if (last_word && s_last) begin
                            state_q   <= ARMED;
                            armed_q   <= 1'b1;
                            s_ready_q <= 1'b0;
                        end else if (last_word || s_last) begin
                            state_q   <= IDLE;
                            err_q     <= 1'b1;
                            s_ready_q <= 1'b0;
                        end else begin
                            wcnt_q <= wcnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    s_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready   = s_ready_q;
    assign armed     = armed_q;
    assign err       = err_q;
    assign out_valid = out_valid_q;

`ifdef NEURON_LUT_READBACK_EN
    logic          rb_act_q;
    logic [CW-1:0] rb_cnt_q;
    logic          rb_end;

    assign rb_end = (rb_cnt_q == CW'(NWORDS - 1));

    always_ff @(posedge clk) begin
        if (rst || load_start || state_q != ARMED) begin
            rb_act_q <= 1'b0;
            rb_cnt_q <= '0;
        end else if (!rb_act_q) begin
            if (rb_start) begin
                rb_act_q <= 1'b1;
                rb_cnt_q <= '0;
            end
        end else if (rb_ready) begin
            if (rb_end) begin
                rb_act_q <= 1'b0;
            end else begin
                rb_cnt_q <= rb_cnt_q + CW'(1);
            end
        end
    end

    assign rb_valid = rb_act_q;
    assign rb_last  = rb_act_q && rb_end;
`endif

    neuron_lut_ram #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS),
        .WORD_W   (WORD_W)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .we_i     (wr_en),
        .waddr_i  (wcnt_q),
        .wdata_i  (s_data),
        .re_i     (rd_en),
        .raddr_i  (M0),
        .rdata_o  (M1)
`ifdef NEURON_LUT_READBACK_EN
        ,
        .rb_addr_i(rb_cnt_q),
        .rb_word_o(rb_data)
`endif
    );

endmodule

// File: tb/tb_neuron_lut_prog.sv
// Scoreboard bench for neuron_lut_prog at default parameters (8-in, 1-out, 8-bit words).
module tb_neuron_lut_prog;

    logic       clk = 1'b0;
    logic       rst, load_start, s_valid, s_last, in_valid;
    logic [7:0] s_data, M0;
    logic       s_ready, armed, err, out_valid;
    logic [0:0] M1;
`ifdef NEURON_LUT_READBACK_EN
    logic       rb_start, rb_ready, rb_valid, rb_last;
    logic [7:0] rb_data;
`endif

    neuron_lut_prog dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .armed      (armed),
        .err        (err),
        .in_valid   (in_valid),
        .M0         (M0),
        .M1         (M1),
        .out_valid  (out_valid)
`ifdef NEURON_LUT_READBACK_EN
        ,
        .rb_start   (rb_start),
        .rb_valid   (rb_valid),
        .rb_ready   (rb_ready),
        .rb_data    (rb_data),
        .rb_last    (rb_last)
`endif
    );

    always #5 clk = ~clk;

    int         n_tot = 0;
    int         n_bad = 0;
    logic       tbl [256];
    logic [7:0] ld [32];
    bit         exp_armed = 1'b0;
    logic       sb [$];
    logic       sb_e;
    int         ov_run = 0;
    int         ov_peak = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Every out_valid must match a pending expected lookup result.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            ov_run++;
            if (ov_run > ov_peak) ov_peak = ov_run;
            if (sb.size() == 0) begin
                chk("sb_unexpected_ov", {31'b0, out_valid}, 32'd0);
            end else begin
                sb_e = sb.pop_front();
                chk("m1", {31'b0, M1}, {31'b0, sb_e});
            end
        end else begin
            ov_run = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load();
        step();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic feed(input int n, input int last_idx);
        for (int k = 0; k < n; k++) begin
            s_valid = 1'b1;
            s_data  = ld[k];
            s_last  = (k == last_idx);
            step();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic commit_model();
        for (int k = 0; k < 32; k++)
            for (int j = 0; j < 8; j++)
                tbl[k*8 + j] = ld[k][j];
    endtask

    task automatic rand_words();
        for (int k = 0; k < 32; k++) ld[k] = 8'($urandom);
    endtask

    task automatic full_load();
        pulse_load();
        feed(32, 31);
        commit_model();
        exp_armed = 1'b1;
    endtask

    task automatic lookup(input logic [7:0] a);
        in_valid = 1'b1;
        M0       = a;
        if (exp_armed) sb.push_back(tbl[a]);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("ov_latency", {31'b0, out_valid}, {31'b0, exp_armed});
    endtask

    task automatic burst();
        ov_peak = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            in_valid = 1'b1;
            M0       = 8'(i);
            sb.push_back(tbl[i]);
        end
        step();
        in_valid = 1'b0;
        repeat (2) step();
        chk("b2b_run", ov_peak, 32'd256);
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        s_data = '0; in_valid = 1'b0; M0 = '0;
`ifdef NEURON_LUT_READBACK_EN
        rb_start = 1'b0; rb_ready = 1'b0;
`endif
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_armed", {31'b0, armed}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_ov", {31'b0, out_valid}, 32'd0);
        chk("rst_sready", {31'b0, s_ready}, 32'd0);
        chk("rst_m1", {31'b0, M1}, 32'd0);

        // Full load of 0xFC words
        for (int k = 0; k < 32; k++) ld[k] = 8'hFC;
        pulse_load();
        chk("load_sready", {31'b0, s_ready}, 32'd1);
        feed(32, 31);
        commit_model();
        exp_armed = 1'b1;
        chk("fc_armed", {31'b0, armed}, 32'd1);
        chk("fc_err", {31'b0, err}, 32'd0);
        chk("fc_sready", {31'b0, s_ready}, 32'd0);
        lookup(8'h00); chk("fc_m1_00", {31'b0, M1}, 32'd0);
        lookup(8'h02); chk("fc_m1_02", {31'b0, M1}, 32'd1);
        lookup(8'hFF); chk("fc_m1_ff", {31'b0, M1}, 32'd1);

        // Random table, back-to-back lookups
        rand_words();
        full_load();
        chk("rnd_armed", {31'b0, armed}, 32'd1);
        burst();

`ifdef NEURON_LUT_READBACK_EN
        begin
            int got_n;
            got_n = 0;
            step(); rb_start = 1'b1;
            step(); rb_start = 1'b0;
            for (int c = 0; c < 200 && got_n < 32; c++) begin
                @(negedge clk);
                rb_ready = c[0];
                if (rb_valid && rb_ready) begin
                    chk("rb_data", {24'b0, rb_data}, {24'b0, ld[got_n]});
                    chk("rb_last", {31'b0, rb_last}, {31'b0, got_n == 31});
                    got_n++;
                end
            end
            step();
            rb_ready = 1'b0;
            step();
            chk("rb_words", got_n, 32'd32);
            chk("rb_idle", {31'b0, rb_valid}, 32'd0);
        end
`endif

        // Early s_last on word 10
        rand_words();
        pulse_load();
        feed(11, 10);
        exp_armed = 1'b0;
        chk("early_err", {31'b0, err}, 32'd1);
        chk("early_armed", {31'b0, armed}, 32'd0);
        chk("early_sready", {31'b0, s_ready}, 32'd0);
        lookup(8'h05);

        // Re-arm, then load_start with a simultaneous lookup, abort on word 20, reload zeros
        rand_words();
        full_load();
        chk("rearm_err", {31'b0, err}, 32'd0);
        step();
        load_start = 1'b1; in_valid = 1'b1; M0 = 8'h03;
        step();
        load_start = 1'b0; in_valid = 1'b0;
        exp_armed = 1'b0;
        @(negedge clk);
        chk("ls_drop_ov", {31'b0, out_valid}, 32'd0);
        chk("ls_armed", {31'b0, armed}, 32'd0);
        rand_words();
        feed(20, -1);
        s_valid = 1'b1; s_data = 8'hAA; load_start = 1'b1;
        step();
        load_start = 1'b0; s_valid = 1'b0;
        for (int k = 0; k < 32; k++) ld[k] = 8'h00;
        feed(32, 31);
        commit_model();
        exp_armed = 1'b1;
        chk("abort_armed", {31'b0, armed}, 32'd1);
        chk("abort_err", {31'b0, err}, 32'd0);
        burst();

        // Reset while armed
        step();
        rst = 1'b1; in_valid = 1'b1; M0 = 8'h00;
        step();
        rst = 1'b0; in_valid = 1'b0;
        exp_armed = 1'b0;
        @(negedge clk);
        chk("rstarm_armed", {31'b0, armed}, 32'd0);
        chk("rstarm_ov", {31'b0, out_valid}, 32'd0);
        step();
        lookup(8'h07);
        rand_words();
        full_load();
        chk("reload_armed", {31'b0, armed}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            step();
            lookup(8'($urandom));
        end

        repeat (3) step();
        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/neuron_lut_prog.md
Name: neuron_lut_prog

Overview:
- Runtime-programmable neuron truth table. Replaces a fixed case-ROM neuron with a loadable table.
- It is the writer side of the neuron LUT. A host streams packed truth-table words in through a valid/ready port, and the block writes them into a distributed 2^IN_BITS x OUT_BITS table.
- Once the table is fully loaded, the block answers M0 -> M1 lookups with registered output.
- Sits in the ensemble layer wrapper wherever a neuron must be re-trained without resynthesis.

Parameters:
- IN_BITS, 8, neuron fan-in address width; DEPTH = 2^IN_BITS entries.
- OUT_BITS, 1, bits per table entry.
- WORD_W, 8, load word width; must be a multiple of OUT_BITS. EPW = WORD_W/OUT_BITS entries per word; NWORDS = DEPTH/EPW.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- load_start  in  1  pulse: begin new table load.
- s_valid  in  1  load word valid.
- s_ready  out  1  load word accepted when s_valid && s_ready.
- s_data  in  WORD_W  packed entries.
- s_last  in  1  marks the final load word.
- armed  out  1  table complete and usable.
- err  out  1  sticky load framing error.
- in_valid  in  1  lookup request.
- M0  in  IN_BITS  lookup address.
- M1  out  OUT_BITS  looked-up entry.
- out_valid  out  1  M1 valid.

Behaviour:
- Reset: clk and rst are the only clock and reset; reset is synchronous, active-high.
  - State goes to IDLE. armed, err, out_valid, s_ready and M1 are all 0; the word counter wcnt is 0.
  - Table contents are not reset.
- FSM states: IDLE, LOAD, ARMED.
  - IDLE --load_start--> LOAD. wcnt := 0, err := 0, armed := 0.
  - LOAD: s_ready = 1. Each accepted word k writes entry j of that word (bits [j*OUT_BITS +: OUT_BITS]) to address k*EPW + j, for j = 0..EPW-1, LSB first. wcnt increments.
  - LOAD, accepted word with wcnt == NWORDS-1 and s_last = 1 -> ARMED; armed := 1 on the next cycle.
  - LOAD, s_last = 1 with wcnt < NWORDS-1, or wcnt == NWORDS-1 with s_last = 0 -> IDLE; err := 1. The partial table is never armed.
  - ARMED --load_start--> LOAD. armed drops on the next cycle.
  - load_start during LOAD restarts the load: wcnt := 0, the current word is not written, err := 0.
- s_ready is 0 in IDLE and ARMED. Words offered there are not consumed.
- Lookup (ARMED only):
  - in_valid at cycle t gives M1 = table[M0] and out_valid = 1 at t+1. This is 1-cycle latency, fully pipelined, one lookup per cycle.
  - out_valid is 0 whenever in_valid was 0 or the state was not ARMED at t. M1 holds its last value when out_valid = 0.
- Simultaneous load_start and in_valid in ARMED: the lookup is dropped (out_valid = 0) and the load starts.
- rst mid-load: returns to IDLE with armed = 0. The table must be fully reloaded before lookups.
- The table is written only in LOAD, so ARMED contents are stable.

Optional Feature:
- Macro: NEURON_LUT_READBACK_EN.
- With the macro defined, the block adds these ports:
  - rb_start (in, 1)
  - rb_valid (out, 1)
  - rb_ready (in, 1)
  - rb_data (out, WORD_W)
  - rb_last (out, 1)
- Readback behaviour:
  - rb_start in ARMED streams NWORDS words in the same packing as the load, with rb_last on the final word.
  - The stream obeys valid/ready: data is held while rb_valid && !rb_ready.
  - Lookups continue during readback.
  - load_start aborts readback: rb_valid goes to 0 the next cycle.
- Without the macro, these ports and the logic behind them are absent.

Decomposition:
- Shared package neuron_lut_pkg holds:
  - the state enum (IDLE/LOAD/ARMED);
  - the functions computing EPW and NWORDS;
  - the counter width localparam, $clog2(NWORDS).
- One sub-module, neuron_lut_ram: DEPTH x OUT_BITS distributed memory with an EPW-wide write port and one registered read port (rom_style distributed). The FSM and counters stay in neuron_lut_prog.

Test Plan:
- Full load, defaults: 32 words with s_data = 8'hFC and s_last on word 31. Then M0 = 8'h00 -> M1 = 0; M0 = 8'h02 -> M1 = 1; M0 = 8'hFF -> M1 = 1. out_valid one cycle after in_valid; armed = 1.
- Back-to-back lookups: M0 = 0..255 with in_valid held high -> 256 consecutive out_valid cycles, each M1 matching the loaded table at t+1.
- Early s_last on word 10 -> err = 1, armed = 0, state IDLE. A lookup gives out_valid = 0.
- load_start asserted on word 20 of a load, followed by a clean 32-word reload of all 0x00 -> armed = 1, err = 0, every lookup returns M1 = 0.
- rst asserted while ARMED -> armed = 0, out_valid = 0. A lookup gives no out_valid; a subsequent load arms again.
- With NEURON_LUT_READBACK_EN, rb_ready toggled every other cycle -> readback returns the 32 loaded words in order with rb_last on word 31, and no word is duplicated or dropped.
